// File: rtl/sd_pkg.sv
// Shared encodings for the SD CMD-line sequencer: response types, FSM states, CRC7.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sd_pkg;

  // Response type encodings presented on rsp_type
  localparam logic [1:0] RSP_NONE      = 2'd0;
  localparam logic [1:0] RSP_R48       = 2'd1;
  localparam logic [1:0] RSP_R48_NOCRC = 2'd2;
  localparam logic [1:0] RSP_R136      = 2'd3;

  // CRC7 generator x^7 + x^3 + 1 (the x^7 term is implicit)
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Command frame layout: 40 CRC-covered bits, 7 CRC bits, 1 end bit
  localparam logic [5:0] TX_CRC_START = 6'd40;
  localparam logic [5:0] TX_END_BIT   = 6'd47;
  localparam logic [5:0] TX_BITS      = 6'd48;

  // Index of the last response bit after the start bit, per response length
  localparam logic [7:0] RX_LAST_R48  = 8'd47;
  localparam logic [7:0] RX_LAST_R136 = 8'd135;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    RECV,
    GAP,
    DONE
  } state_t;

  // One serial CRC7 step, MSB-first
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one bit per enabled cycle, cleared to zero by clr.
// Latency: crc reflects a bit one clk after en.
// Backpressure: none; caller gates en.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  // CRC register: clear wins over shifting in a new bit
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line sequencer: SD_CLK generation, 48-bit command TX, R48/R136 RX with CRC7, NCC gap.
// Latency: done asserts one clk after the NCC-th gap rise strobe; busy rises one clk after accept.
// Backpressure: start is only accepted while busy=0; requests during busy are dropped.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NCR_MAX = 64,
  parameter int NCC     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   rsp_type,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         crc_err,
  output logic [127:0] rsp_data,
  output logic         sd_clk,
  output logic         cmd_out,
  output logic         cmd_oe,
  input  logic         cmd_in
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int NCR_W = $clog2(NCR_MAX + 1);
  localparam int NCC_W = $clog2(NCC + 1);

  state_t             state;
  state_t             state_nxt;
  logic [DIV_W-1:0]   div;
  logic               wrap;
  logic               rise;
  logic               fall;
  logic               accept;

  logic [1:0]         typ;
  logic [39:0]        tx_sr;
  logic [5:0]         bit_cnt;
  logic [2:0]         crc_idx;
  logic               tx_bit;
  logic [6:0]         tx_crc;

  logic [NCR_W-1:0]   ncr_cnt;
  logic               ncr_last;
  logic [7:0]         rx_cnt;
  logic [7:0]         rx_last_idx;
  logic [7:0]         rx_pos;
  logic               rx_last;
  logic               rx_crc_en;
  logic [6:0]         rx_crc;

  logic [NCC_W-1:0]   gap_cnt;
  logic               gap_last;

  // Strobes derived from the free-running divider; they mark the cycle whose edge toggles sd_clk
  assign wrap = (div == DIV_W'(CLK_DIV - 1));
  assign rise = wrap & ~sd_clk;
  assign fall = wrap &  sd_clk;

  assign accept = start & ~busy;

  // Outgoing bit: shifted header/argument, then CRC7 MSB-first, then the end bit
  assign crc_idx = 3'(6'd46 - bit_cnt);
  assign tx_bit  = (bit_cnt < TX_CRC_START) ? tx_sr[39] :
                   (bit_cnt < TX_END_BIT)   ? tx_crc[crc_idx] : 1'b1;

  // Position of the response bit arriving on this rise, counted from the response MSB
  assign rx_last_idx = (typ == RSP_R136) ? RX_LAST_R136 : RX_LAST_R48;
  assign rx_pos      = rx_last_idx - rx_cnt;
  assign rx_last     = (rx_cnt == rx_last_idx);
  // R48 covers [47:8] (start bit adds nothing to a zero register); R136 covers [127:8]
  assign rx_crc_en   = (state == RECV) && rise && (rx_pos >= 8'd8) && (rx_pos <= 8'd127);

  assign ncr_last = (ncr_cnt == NCR_W'(NCR_MAX - 1));
  assign gap_last = (gap_cnt == NCC_W'(NCC - 1));

  sd_crc7 u_tx_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    ((state == SEND) && fall && (bit_cnt < TX_CRC_START)),
    .din   (tx_sr[39]),
    .crc   (tx_crc)
  );

  sd_crc7 u_rx_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (rx_crc_en),
    .din   (cmd_in),
    .crc   (rx_crc)
  );

  // Free-running clock divider producing sd_clk
  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      sd_clk <= 1'b0;
    end else if (wrap) begin
      div    <= '0;
      sd_clk <= ~sd_clk;
    end else begin
      div    <= div + DIV_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and status outputs; busy drops in DONE so a new start can be taken there
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SEND;
      end
      SEND: begin
        if (fall && (bit_cnt == TX_BITS)) begin
          state_nxt = (typ == RSP_NONE) ? GAP : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rise) begin
          if (!cmd_in)       state_nxt = RECV;
          else if (ncr_last) state_nxt = GAP;
        end
      end
      RECV: begin
        if (rise && rx_last) state_nxt = GAP;
      end
      GAP: begin
        if (rise && gap_last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = start ? SEND : IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Command transmitter: pad drive changes only on fall strobes; release after bit 47 has been held
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_out <= 1'b1;
      cmd_oe  <= 1'b0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      typ     <= RSP_NONE;
    end else if (accept) begin
      tx_sr   <= {2'b01, cmd_index, cmd_arg};
      bit_cnt <= '0;
      typ     <= rsp_type;
    end else if ((state == SEND) && fall) begin
      if (bit_cnt == TX_BITS) begin
        cmd_oe  <= 1'b0;
        cmd_out <= 1'b1;
      end else begin
        cmd_oe  <= 1'b1;
        cmd_out <= tx_bit;
        bit_cnt <= bit_cnt + 6'd1;
        if (bit_cnt < TX_CRC_START) tx_sr <= {tx_sr[38:0], 1'b0};
      end
    end
  end

  // Response receiver: NCR wait, bit capture on rise strobes, final CRC/end-bit judgement
  always_ff @(posedge clk) begin
    if (reset) begin
      ncr_cnt  <= '0;
      rx_cnt   <= '0;
      rsp_data <= '0;
      timeout  <= 1'b0;
      crc_err  <= 1'b0;
    end else if (accept) begin
      ncr_cnt  <= '0;
      rx_cnt   <= '0;
      rsp_data <= '0;
      timeout  <= 1'b0;
      crc_err  <= 1'b0;
    end else if (rise && (state == WAIT_RSP)) begin
      if (!cmd_in) begin
        rx_cnt  <= 8'd1;
      end else if (ncr_last) begin
        timeout <= 1'b1;
      end else begin
        ncr_cnt <= ncr_cnt + NCR_W'(1);
      end
    end else if (rise && (state == RECV)) begin
      rx_cnt <= rx_cnt + 8'd1;
      if (rx_last) begin
        // rsp_data[6:0] holds received bits [7:1]; cmd_in is the end bit
        crc_err <= !cmd_in || ((typ != RSP_R48_NOCRC) && (rsp_data[6:0] != rx_crc));
        if (typ == RSP_R136) begin
          rsp_data <= {rsp_data[126:0], cmd_in};
        end else begin
          rsp_data <= {90'b0, rsp_data[44:7]};
        end
      end else begin
        rsp_data <= {rsp_data[126:0], cmd_in};
      end
    end
  end

  // NCC gap counter, only live while in GAP
  always_ff @(posedge clk) begin
    if (reset || (state != GAP)) begin
      gap_cnt <= '0;
    end else if (rise) begin
      gap_cnt <= gap_cnt + NCC_W'(1);
    end
  end

endmodule
